// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbiter: op codes, flag bit positions,
// arbiter state encoding and the op legality check.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_ADDU = 4'b1010;
  localparam logic [3:0] OP_SUBU = 4'b1011;

  localparam int ZF = 3;
  localparam int SF = 2;
  localparam int CF = 1;
  localparam int OF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND,
      OP_SUB, OP_SRA, OP_ADDU, OP_SUBU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational ALU. Flags are {ZF,SF,CF,OF}; CF is carry-out for adds and
// borrow for subtracts, OF is signed overflow for the signed add/sub only.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_lhs,
  input  logic [31:0] i_rhs,
  output logic [31:0] o_res,
  output logic [3:0]  o_flags
);

  logic [32:0] w_sum;
  logic [32:0] w_dif;
  logic        w_add_ov;
  logic        w_sub_ov;
  logic        w_cf;
  logic        w_of;

  assign w_sum    = {1'b0, i_lhs} + {1'b0, i_rhs};
  assign w_dif    = {1'b0, i_lhs} - {1'b0, i_rhs};
  assign w_add_ov = (i_lhs[31] == i_rhs[31]) && (w_sum[31] != i_lhs[31]);
  assign w_sub_ov = (i_lhs[31] != i_rhs[31]) && (w_dif[31] != i_lhs[31]);

  always_comb begin
    o_res = '0;
    w_cf  = 1'b0;
    w_of  = 1'b0;
    case (i_op)
      OP_ADD:  begin o_res = w_sum[31:0]; w_cf = w_sum[32]; w_of = w_add_ov; end
      OP_ADDU: begin o_res = w_sum[31:0]; w_cf = w_sum[32]; end
      OP_SUB:  begin o_res = w_dif[31:0]; w_cf = w_dif[32]; w_of = w_sub_ov; end
      OP_SUBU: begin o_res = w_dif[31:0]; w_cf = w_dif[32]; end
      OP_SLL:  o_res = i_lhs << i_rhs[4:0];
      OP_SRA:  o_res = $signed(i_lhs) >>> i_rhs[4:0];
      OP_SLT:  o_res = {31'b0, $signed(i_lhs) < $signed(i_rhs)};
      OP_SLTU: o_res = {31'b0, i_lhs < i_rhs};
      OP_XOR:  o_res = i_lhs ^ i_rhs;
      OP_OR:   o_res = i_lhs | i_rhs;
      OP_AND:  o_res = i_lhs & i_rhs;
      default: o_res = '0;
    endcase
  end

  always_comb begin
    o_flags     = '0;
    o_flags[ZF] = (o_res == 32'd0);
    o_flags[SF] = o_res[31];
    o_flags[CF] = w_cf;
    o_flags[OF] = w_of;
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// wrapping modulo N. Emits a one-hot grant and the winner's index.
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_idx
);

  logic [IDW-1:0] w_idx;
  logic           w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_idx   = i_ptr;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!w_found && (w_idx == IDW'(j)) && i_req[j]) begin
          o_gnt[j] = 1'b1;
          o_idx    = IDW'(j);
          w_found  = 1'b1;
        end
      end
      w_idx = (w_idx == IDW'(N - 1)) ? '0 : w_idx + IDW'(1);
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between N requesters: grant in IDLE,
// execute from registered operands in EXEC, hold the registered response in RESP.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      i_req_valid,
  output logic [N-1:0]      o_req_ready,
  input  logic [4*N-1:0]    i_req_op,
  input  logic [32*N-1:0]   i_req_lhs,
  input  logic [32*N-1:0]   i_req_rhs,
  output logic [N-1:0]      o_rsp_valid,
  input  logic [N-1:0]      i_rsp_ready,
  output logic [31:0]       o_rsp_res,
  output logic [3:0]        o_rsp_flags,
  output logic              o_rsp_err,
  output logic [IDW-1:0]    o_rsp_id,
  output logic              o_busy,
  output logic [15:0]       o_ops_done
);

  arb_state_t     r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [3:0]     r_op;
  logic [31:0]    r_lhs;
  logic [31:0]    r_rhs;
  logic [31:0]    r_res;
  logic [3:0]     r_flags;
  logic           r_err;
  logic [15:0]    r_ops_done;

  logic [N-1:0]   w_gnt;
  logic [IDW-1:0] w_win;
  logic           w_any;
  logic [3:0]     w_sel_op;
  logic [31:0]    w_sel_lhs;
  logic [31:0]    w_sel_rhs;
  logic [31:0]    w_alu_res;
  logic [3:0]     w_alu_flags;
  logic           w_rsp_hs;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_win)
  );

  alu u_alu (
    .i_op    (r_op),
    .i_lhs   (r_lhs),
    .i_rhs   (r_rhs),
    .o_res   (w_alu_res),
    .o_flags (w_alu_flags)
  );

  assign w_any = |i_req_valid;

  always_comb begin
    w_sel_op  = '0;
    w_sel_lhs = '0;
    w_sel_rhs = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        w_sel_op  = i_req_op[4*i +: 4];
        w_sel_lhs = i_req_lhs[32*i +: 32];
        w_sel_rhs = i_req_rhs[32*i +: 32];
      end
    end
  end

  // Only the owner's rsp_ready counts, and only while a response is presented.
  always_comb begin
    o_rsp_valid = '0;
    w_rsp_hs    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ((r_state == RESP) && (r_id == IDW'(i))) begin
        o_rsp_valid[i] = 1'b1;
        w_rsp_hs       = i_rsp_ready[i];
      end
    end
  end

  assign o_req_ready = (rst_n && (r_state == IDLE)) ? w_gnt : '0;
  assign o_rsp_res   = r_res;
  assign o_rsp_flags = r_flags;
  assign o_rsp_err   = r_err;
  assign o_rsp_id    = r_id;
  assign o_busy      = (r_state != IDLE);
  assign o_ops_done  = r_ops_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_id       <= '0;
      r_op       <= '0;
      r_lhs      <= '0;
      r_rhs      <= '0;
      r_res      <= '0;
      r_flags    <= '0;
      r_err      <= 1'b0;
      r_ops_done <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op    <= w_sel_op;
            r_lhs   <= w_sel_lhs;
            r_rhs   <= w_sel_rhs;
            r_id    <= w_win;
            r_ptr   <= (w_win == IDW'(N - 1)) ? '0 : w_win + IDW'(1);
            r_state <= EXEC;
          end
        end
        EXEC: begin
          // Illegal ops still take the full sequence but never expose ALU output.
          if (op_is_legal(r_op)) begin
            r_res   <= w_alu_res;
            r_flags <= w_alu_flags;
            r_err   <= 1'b0;
          end else begin
            r_res   <= '0;
            r_flags <= '0;
            r_err   <= 1'b1;
          end
          r_state <= RESP;
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_ops_done <= r_ops_done + 16'd1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the arbiter and ALU.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N   = 3;
  localparam int IDW = 3;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      i_req_valid;
  logic [N-1:0]      o_req_ready;
  logic [4*N-1:0]    i_req_op;
  logic [32*N-1:0]   i_req_lhs;
  logic [32*N-1:0]   i_req_rhs;
  logic [N-1:0]      o_rsp_valid;
  logic [N-1:0]      i_rsp_ready;
  logic [31:0]       o_rsp_res;
  logic [3:0]        o_rsp_flags;
  logic              o_rsp_err;
  logic [IDW-1:0]    o_rsp_id;
  logic              o_busy;
  logic [15:0]       o_ops_done;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_op    (i_req_op),
    .i_req_lhs   (i_req_lhs),
    .i_req_rhs   (i_req_rhs),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_res   (o_rsp_res),
    .o_rsp_flags (o_rsp_flags),
    .o_rsp_err   (o_rsp_err),
    .o_rsp_id    (o_rsp_id),
    .o_busy      (o_busy),
    .o_ops_done  (o_ops_done)
  );

  // stimulus the next cycle() applies
  logic         d_rst_n;
  logic [N-1:0] d_valid;
  logic [3:0]   d_op  [N];
  logic [31:0]  d_lhs [N];
  logic [31:0]  d_rhs [N];
  logic [N-1:0] d_rsp_ready;

  // transaction-level model
  int          m_ptr;
  bit          m_inflight;
  int          m_age;
  int          m_id;
  logic [31:0] m_res;
  logic [3:0]  m_flags;
  bit          m_err;
  logic [15:0] m_count;
  bit          m_granted [N];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_alu(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic [3:0] f, output bit err);
    longint sa, sb, ua, ub, s;
    bit c, o;
    int sh;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b[4:0]);
    c = 0; o = 0; err = 0; r = '0;
    case (op)
      4'd0:  begin r = 32'(ua + ub); c = (ua + ub) > 64'hFFFF_FFFF;
                   s = sa + sb; o = (s > SMAX) || (s < SMIN); end
      4'd10: begin r = 32'(ua + ub); c = (ua + ub) > 64'hFFFF_FFFF; end
      4'd8:  begin r = 32'(ua - ub); c = ua < ub;
                   s = sa - sb; o = (s > SMAX) || (s < SMIN); end
      4'd11: begin r = 32'(ua - ub); c = ua < ub; end
      4'd1:  r = 32'(ua << sh);
      4'd9:  r = 32'(sa >>> sh);
      4'd2:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  r = (ua < ub) ? 32'd1 : 32'd0;
      4'd4:  r = a ^ b;
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      default: err = 1;
    endcase
    if (err) f = 4'd0;
    else     f = {r == 32'd0, r[31], c, o};
  endfunction

  function automatic int model_pick();
    for (int k = 0; k < N; k++)
      if (d_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_inflight = 0; m_age = 0; m_id = 0; m_count = '0;
    for (int i = 0; i < N; i++) m_granted[i] = 0;
  endfunction

  function automatic void model_step();
    int w;
    for (int i = 0; i < N; i++) m_granted[i] = 0;
    if (!d_rst_n) begin
      model_reset();
    end else if (!m_inflight) begin
      w = model_pick();
      if (w >= 0) begin
        m_inflight = 1; m_age = 0; m_id = w;
        model_alu(d_op[w], d_lhs[w], d_rhs[w], m_res, m_flags, m_err);
        m_ptr = (w + 1) % N;
        m_granted[w] = 1;
      end
    end else if (m_age >= 1 && d_rsp_ready[m_id]) begin
      m_inflight = 0;
      m_count    = m_count + 16'd1;
    end else begin
      m_age = 1;
    end
  endfunction

  task automatic compare();
    logic [N-1:0] exp_rdy, exp_rv;
    int w;
    exp_rdy = '0;
    exp_rv  = '0;
    w = model_pick();
    if (d_rst_n && !m_inflight && w >= 0) exp_rdy[w] = 1'b1;
    if (m_inflight && m_age >= 1) exp_rv[m_id] = 1'b1;
    chk("req_ready", 32'(o_req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(o_rsp_valid), 32'(exp_rv));
    chk("busy", 32'(o_busy), 32'(m_inflight));
    chk("ops_done", 32'(o_ops_done), 32'(m_count));
    if (exp_rv != '0) begin
      chk("rsp_res", o_rsp_res, m_res);
      chk("rsp_flags", 32'(o_rsp_flags), 32'(m_flags));
      chk("rsp_err", 32'(o_rsp_err), 32'(m_err));
      chk("rsp_id", 32'(o_rsp_id), 32'(m_id));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    rst_n       = d_rst_n;
    i_req_valid = d_valid;
    i_rsp_ready = d_rsp_ready;
    for (int i = 0; i < N; i++) begin
      i_req_op[4*i +: 4]   = d_op[i];
      i_req_lhs[32*i +: 32] = d_lhs[i];
      i_req_rhs[32*i +: 32] = d_rhs[i];
    end
    #1;
    if (!d_rst_n) model_reset();
    compare();
    model_step();
  endtask

  task automatic do_reset();
    d_rst_n = 0;
    d_valid = '0;
    cycle();
    cycle();
    d_rst_n = 1;
    cycle();
  endtask

  // Present one request alone, wait for its grant, then advance into RESP.
  task automatic run_op(input int id, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    n = 0;
    d_valid = '0;
    d_valid[id] = 1'b1;
    d_op[id] = op; d_lhs[id] = a; d_rhs[id] = b;
    cycle();
    while (o_req_ready[id] !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    chk("grant", 32'(o_req_ready), 32'(1) << id);
    d_valid[id] = 1'b0;
    cycle();
    cycle();
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int gq[$];
    int rq;
    int exp_order[4];

    rst_n = 0;
    i_req_valid = '0; i_rsp_ready = '0; i_req_op = '0; i_req_lhs = '0; i_req_rhs = '0;
    d_rsp_ready = '1;
    for (int i = 0; i < N; i++) begin d_op[i] = '0; d_lhs[i] = '0; d_rhs[i] = '0; end
    model_reset();
    do_reset();

    // reset state
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ops", 32'(o_ops_done), 32'd0);
    chk("rst_res", o_rsp_res, 32'd0);
    chk("rst_flags", 32'(o_rsp_flags), 32'd0);
    chk("rst_id", 32'(o_rsp_id), 32'd0);

    // single add with carry-out to zero
    d_valid = 3'b001; d_op[0] = OP_ADD; d_lhs[0] = 32'hFFFF_FFFF; d_rhs[0] = 32'h1;
    cycle();
    chk("single_grant", 32'(o_req_ready), 32'b001);
    d_valid = '0;
    cycle();
    chk("single_t1_valid", 32'(o_rsp_valid), 32'd0);
    cycle();
    chk("single_t2_valid", 32'(o_rsp_valid), 32'b001);
    chk("single_res", o_rsp_res, 32'h0);
    chk("single_flags", 32'(o_rsp_flags), 32'b1010);
    chk("single_err", 32'(o_rsp_err), 32'd0);
    cycle();
    chk("single_ops", 32'(o_ops_done), 32'd1);

    // contention from reset: grant order must alternate 0,1,0,1
    do_reset();
    d_valid = 3'b011;
    for (int i = 0; i < 2; i++) begin d_op[i] = OP_SUB; d_lhs[i] = 32'h1; d_rhs[i] = 32'h2; end
    rq = 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (o_req_ready != '0) gq.push_back(oh_idx(o_req_ready));
      if (o_rsp_valid != '0 && rq < gq.size()) begin
        chk("cont_res", o_rsp_res, 32'hFFFF_FFFF);
        chk("cont_sf", 32'(o_rsp_flags[SF]), 32'd1);
        chk("cont_id", 32'(o_rsp_id), 32'(gq[rq]));
        rq++;
      end
    end
    d_valid = '0;
    exp_order = '{0, 1, 0, 1};
    chk("cont_grants", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("cont_order", 32'(gq[i]), 32'(exp_order[i]));

    // backpressure on requester 1; others' rsp_ready must be ignored
    do_reset();
    d_rsp_ready = 3'b101;
    d_valid = 3'b010; d_op[1] = OP_SRA; d_lhs[1] = 32'hFFFF_FFFF; d_rhs[1] = 32'd3;
    cycle();
    chk("bp_grant", 32'(o_req_ready), 32'b010);
    d_valid = 3'b001; d_op[0] = OP_ADD; d_lhs[0] = 32'd5; d_rhs[0] = 32'd6;
    cycle();
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("bp_valid", 32'(o_rsp_valid), 32'b010);
      chk("bp_res", o_rsp_res, 32'hFFFF_FFFF);
      chk("bp_flags", 32'(o_rsp_flags), 32'b0100);
      chk("bp_ready0", 32'(o_req_ready), 32'd0);
    end
    d_rsp_ready = 3'b010;
    cycle();
    chk("bp_release_valid", 32'(o_rsp_valid), 32'b010);
    cycle();
    chk("bp_idle", 32'(o_busy), 32'd0);
    chk("bp_next_grant", 32'(o_req_ready), 32'b001);
    d_valid = '0; d_rsp_ready = '1;
    cycle();
    cycle();
    chk("bp_next_res", o_rsp_res, 32'd11);
    cycle();

    // illegal op, then a legal one
    run_op(0, 4'b0101, 32'h1234_5678, 32'h9);
    chk("ill_res", o_rsp_res, 32'h0);
    chk("ill_flags", 32'(o_rsp_flags), 32'h0);
    chk("ill_err", 32'(o_rsp_err), 32'd1);
    cycle();
    run_op(2, OP_AND, 32'h0D00_0001, 32'h0F00_0001);
    chk("and_res", o_rsp_res, 32'h0D00_0001);
    chk("and_err", 32'(o_rsp_err), 32'd0);
    cycle();

    // reset during EXEC discards the operation
    d_valid = 3'b001; d_op[0] = OP_ADD; d_lhs[0] = 32'h7FFF_FFFF; d_rhs[0] = 32'h1000_0003;
    cycle();
    d_valid = '0;
    cycle();
    chk("mid_busy", 32'(o_busy), 32'd1);
    d_rst_n = 0;
    rst_n = 0;
    #1;
    model_reset();
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("mid_rst_res", o_rsp_res, 32'd0);
    chk("mid_rst_ops", 32'(o_ops_done), 32'd0);
    cycle();
    cycle();
    d_rst_n = 1;
    cycle();
    cycle();
    chk("mid_no_rsp", 32'(o_rsp_valid), 32'd0);
    run_op(0, OP_ADD, 32'h7FFF_FFFF, 32'h1000_0003);
    chk("mid_res", o_rsp_res, 32'h9000_0002);
    chk("mid_flags", 32'(o_rsp_flags), 32'b0101);
    cycle();

    // counter wrap: preload to 0xFFFE, three more handshakes reach 0x0001
    force dut.r_ops_done = 16'hFFFE;
    #1;
    release dut.r_ops_done;
    m_count = 16'hFFFE;
    run_op(1, OP_XOR, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    cycle();
    chk("wrap_ffff", 32'(o_ops_done), 32'h0000_FFFF);
    run_op(0, OP_OR, 32'h0, 32'h0);
    cycle();
    chk("wrap_0000", 32'(o_ops_done), 32'h0000_0000);
    run_op(2, OP_SLT, 32'hFFFF_FFFF, 32'h1);
    chk("wrap_slt", o_rsp_res, 32'h1);
    cycle();
    chk("wrap_0001", 32'(o_ops_done), 32'h0000_0001);

    // randomized traffic; a requester holds its request until granted
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(d_valid[i] && !m_granted[i])) begin
          d_valid[i] = ($urandom_range(0, 99) < 40);
          d_op[i]    = 4'($urandom_range(0, 15));
          d_lhs[i]   = rand_val();
          d_rhs[i]   = rand_val();
        end
      end
      for (int i = 0; i < N; i++) d_rsp_ready[i] = ($urandom_range(0, 99) < 55);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU (4-bit op, 32-bit lhs/rhs, 32-bit result, flags {ZF,SF,CF,OF}) between N requesters using valid/ready handshakes. A round-robin grant selects one request, registers its operands, executes it on the ALU, and returns the registered result and flags to the granted requester. It sits between the execute-stage clients (integer pipe, address generator, debug port) and the shared ALU instance.

Parameters:
N, 2, number of requesters (2..8)
IDW, 3, width of the requester index (must satisfy 2^IDW >= N)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  N  requester i presents a request
req_ready  out  N  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
req_op  in  4*N  ALU op per requester, packed with requester i at [4i+3:4i]
req_lhs  in  32*N  left operand per requester, packed
req_rhs  in  32*N  right operand per requester, packed
rsp_valid  out  N  one-hot; result is available for requester i
rsp_ready  in  N  requester i accepts the result
rsp_res  out  32  result, shared by all requesters, qualified by rsp_valid
rsp_flags  out  4  {ZF,SF,CF,OF} from the ALU, shared, qualified by rsp_valid
rsp_err  out  1  op was illegal; qualified by rsp_valid
rsp_id  out  IDW  index of the requester that owns the current response
busy  out  1  high whenever state is not IDLE
ops_done  out  16  count of completed response handshakes; wraps at 2^16

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE. Round-robin pointer ptr=0.
  - Operand registers, rsp_res, rsp_flags, rsp_err, rsp_id, ops_done, busy all 0.
  - req_ready and rsp_valid are 0 during reset.
  - A reset in EXEC or RESP discards the in-flight operation with no response.
- State machine:
  - IDLE:
    - Winner = first i with req_valid[i], searching ptr, ptr+1, … mod N.
    - req_ready[winner]=1 combinationally. It is never asserted for a non-valid requester and never asserted outside IDLE.
    - On the handshake: capture op/lhs/rhs/winner, set ptr=(winner+1) mod N, go to EXEC.
    - With no request, stay in IDLE.
  - EXEC: the ALU is driven from the operand registers. Register the ALU res and flags into rsp_res and rsp_flags, then go to RESP.
  - RESP:
    - rsp_valid[rsp_id]=1. rsp_res, rsp_flags, rsp_err and rsp_id are held stable.
    - When rsp_ready[rsp_id]=1: increment ops_done, go to IDLE.
    - Otherwise hold indefinitely (backpressure).
- Latency and throughput:
  - The grant cycle is T. rsp_valid rises at T+2.
  - The earliest next grant is the cycle after the response handshake. Peak throughput is one operation per 3 cycles.
  - There is no grant/response overlap.
- Legal ops: 0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0110 or, 0111 and, 1000 sub, 1001 sra, 1010 addu, 1011 subu.
- Illegal ops (0101, 1100–1111):
  - Accepted normally and sequenced through EXEC.
  - Return rsp_res=0, rsp_flags=0, rsp_err=1. The ALU output is ignored.
- Flags and result are passed through exactly as the ALU produces them. No reinterpretation.
- Requester rules:
  - After raising req_valid, a requester holds it and its payload stable until granted.
  - The arbiter does not check this. Payload changes before the grant are simply sampled at the grant.
- Simultaneous requests: exactly one grant per IDLE cycle. Every continuously-valid requester is granted within N grants.
- rsp_ready asserted by a requester other than rsp_id, or asserted outside RESP, is ignored.
- ops_done wraps from 0xFFFF to 0x0000 with no saturation.

Decomposition:
- Shared package alu_pkg holds:
  - The 4-bit op localparams: OP_ADD=0000, OP_SLL=0001, OP_SLT=0010, OP_SLTU=0011, OP_XOR=0100, OP_OR=0110, OP_AND=0111, OP_SUB=1000, OP_SRA=1001, OP_ADDU=1010, OP_SUBU=1011.
  - The flag bit indices ZF=3, SF=2, CF=1, OF=0.
  - The arbiter state encoding IDLE/EXEC/RESP.
- Sub-modules:
  - rr_pick (parameter N): combinational round-robin picker. Inputs are the req vector and ptr; outputs are a one-hot grant and the winner index.
  - The existing ALU module, instantiated once.

Test Plan:
- Single request: requester 0, add, 0xFFFF_FFFF + 0x0000_0001 -> granted at T; rsp_valid[0] at T+2; res=0x0000_0000; ZF=1, CF=1; rsp_err=0; ops_done=1.
- Contention: requesters 0 and 1 valid continuously from reset, both issuing sub 0x0000_0001 - 0x0000_0002, with rsp_ready tied high -> grant order 0,1,0,1; every result is 0xFFFF_FFFF with SF=1; each response's rsp_id matches its grant.
- Backpressure: requester 1 issues sra 0xFFFF_FFFF >> 3 and holds rsp_ready=0 for 5 cycles -> rsp_valid[1] and res=0xFFFF_FFFF held stable; req_ready stays 0 for requester 0; after rsp_ready rises, state returns to IDLE and requester 0 is then granted.
- Illegal op: op=0101 with lhs=0x1234_5678 -> rsp_res=0, rsp_flags=0, rsp_err=1; the next legal op (and 0x0D00_0001 & 0x0F00_0001) returns 0x0D00_0001 with rsp_err=0.
- Reset mid-operation: assert rst_n=0 during EXEC of add 0x7FFF_FFFF + 0x1000_0003 -> outputs go to 0 immediately and no rsp_valid follows; after release, the same request returns 0x9000_0002 with SF=1, OF=1.
- Counter wrap: preload the bench to drive 65 537 completed handshakes -> ops_done reads 0x0001.
